io_handshake_port: RTL

- External I/O partner for the processor's byte-wide bus and hs_in/hs_out handshake. It is the far end of the processor's IN/OUT transfers.
- Captures bytes the processor writes on bus_out into an RX FIFO, and supplies bytes to the processor on bus_in from a TX FIFO.
- Answers every processor strobe on hs_out with a four-phase acknowledge on hs_in.
- A host-side FIFO interface lets the testbench or a peripheral fill the TX FIFO and drain the RX FIFO.

---
 rtl/io_handshake_port_if.sv | 14 +
 rtl/io_handshake_port.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/io_handshake_port_if.sv
// Processor-side byte bus and four-phase hs_out/hs_in handshake.
// The processor is the master; the I/O port is the slave.
interface io_handshake_port_if #(
  parameter int unsigned D_W = 8
);
  logic [D_W-1:0] bus_out;
  logic           hs_out;
  logic           io_dir;
  logic [D_W-1:0] bus_in;
  logic           hs_in;

  modport master (output bus_out, hs_out, io_dir, input bus_in, hs_in);
  modport slave  (input bus_out, hs_out, io_dir, output bus_in, hs_in);
endinterface

// File: rtl/io_handshake_port.sv
// Far end of the processor's IN/OUT transfers.
// An RX FIFO collects processor writes, and a TX FIFO feeds processor reads.
module io_handshake_port #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned D_W    = 8
) (
  input  logic                g_clk,
  input  logic                g_clr,
  io_handshake_port_if.slave  proc,
  input  logic                tx_wr_en,
  input  logic [D_W-1:0]      tx_data,
  output logic                tx_full,
  input  logic                rx_rd_en,
  output logic [D_W-1:0]      rx_data,
  output logic                rx_empty,
  output logic [ADDR_W:0]     tx_count,
  output logic [ADDR_W:0]     rx_count,
  output logic                overflow,
  output logic                underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;

  typedef enum logic {IDLE, ACK} state_e;

  state_e            state_q, state_d;
  logic              hs_in_q, hs_in_d;
  logic [D_W-1:0]    bus_in_q, bus_in_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic [D_W-1:0]    tx_mem_q [DEPTH];
  logic [D_W-1:0]    rx_mem_q [DEPTH];
  logic [ADDR_W-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [ADDR_W-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  logic tx_full_c, tx_empty_c, rx_full_c, rx_empty_c;
  logic tx_push, tx_pop, rx_push, rx_pop;

  // All FIFO decisions use start-of-cycle occupancy.
  always_comb begin
    tx_full_c  = (tx_cnt_q == CW'(DEPTH));
    tx_empty_c = (tx_cnt_q == '0);
    rx_full_c  = (rx_cnt_q == CW'(DEPTH));
    rx_empty_c = (rx_cnt_q == '0);
  end

  // Handshake FSM: a strobe is acknowledged only once its FIFO can move a byte.
  always_comb begin
    state_d  = state_q;
    hs_in_d  = hs_in_q;
    bus_in_d = bus_in_q;
    rx_push  = 1'b0;
    tx_pop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (proc.hs_out) begin
          if (proc.io_dir) begin
            if (!rx_full_c) begin
              rx_push = 1'b1;
              state_d = ACK;
              hs_in_d = 1'b1;
            end
          end else if (!tx_empty_c) begin
            tx_pop   = 1'b1;
            bus_in_d = tx_mem_q[tx_rp_q];
            state_d  = ACK;
            hs_in_d  = 1'b1;
          end
        end
      end
      ACK: begin
        if (!proc.hs_out) begin
          state_d = IDLE;
          hs_in_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        hs_in_d = 1'b0;
      end
    endcase
  end

  // Host side: illegal push/pop is dropped and flagged.
  always_comb begin
    tx_push  = tx_wr_en && !tx_full_c;
    rx_pop   = rx_rd_en && !rx_empty_c;
    ovf_d    = ovf_q | (tx_wr_en & tx_full_c);
    udf_d    = udf_q | (rx_rd_en & rx_empty_c);

    tx_wp_d  = tx_push ? tx_wp_q + ADDR_W'(1) : tx_wp_q;
    tx_rp_d  = tx_pop  ? tx_rp_q + ADDR_W'(1) : tx_rp_q;
    rx_wp_d  = rx_push ? rx_wp_q + ADDR_W'(1) : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + ADDR_W'(1) : rx_rp_q;

    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
  end

  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      state_q  <= IDLE;
      hs_in_q  <= 1'b0;
      bus_in_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      hs_in_q  <= hs_in_d;
      bus_in_q <= bus_in_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  // Storage needs no reset; the cleared pointers make stale entries unreachable.
  always_ff @(posedge g_clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= tx_data;
    if (rx_push) rx_mem_q[rx_wp_q] <= proc.bus_out;
  end

  assign proc.bus_in = bus_in_q;
  assign proc.hs_in  = hs_in_q;
  assign tx_full     = tx_full_c;
  assign rx_empty    = rx_empty_c;
  assign rx_data     = rx_mem_q[rx_rp_q];
  assign tx_count    = tx_cnt_q;
  assign rx_count    = rx_cnt_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

endmodule
